// File: rtl/list_collector.sv
// Collects a batch of stream beats into a packed vector for the insertion sorter,
// launches the sort with a one-cycle sort_en and holds the batch until sort_done.
//
// state   | meaning
// --------+------------------------------------------------------------
// FILL    | accepting beats; launches on in_last, full buffer or flush
// WAIT    | batch handed to the sorter; outputs frozen until sort_done
module list_collector #(
  parameter  int DATA_WIDTH = 32,
  parameter  int LENGTH     = 8,
  localparam int LEN_WIDTH  = $clog2(LENGTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic                         in_order,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [LENGTH*DATA_WIDTH-1:0] data_out,
  output logic [LEN_WIDTH-1:0]         len,
  output logic                         sort_order,
  output logic                         sort_en,
  input  logic                         sort_done,
  output logic                         busy
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [LEN_WIDTH-1:0] CNT_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] CNT_LAST = LEN_WIDTH'(LENGTH - 1);

  logic [0:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  order_q, order_d;
  logic                  sort_en_q, sort_en_d;
  logic [DATA_WIDTH-1:0] elem_q [LENGTH];
  logic [DATA_WIDTH-1:0] elem_d [LENGTH];

  logic                  accept;
  logic [LEN_WIDTH-1:0]  count_next;
  logic                  launch;

  assign in_ready   = (state_q == ST_FILL);
  assign busy       = (state_q == ST_WAIT);
  assign len        = len_q;
  assign sort_order = order_q;
  assign sort_en    = sort_en_q;

  for (genvar g = 0; g < LENGTH; g++) begin : g_pack
    assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = elem_q[g];
  end

  assign accept     = in_valid && in_ready;
  assign count_next = accept ? (count_q + CNT_ONE) : count_q;

  // A full buffer always launches, so count can never run past LENGTH.
  assign launch = in_ready &&
                  ((accept && (in_last || (count_q == CNT_LAST))) ||
                   (flush && (count_next != '0)));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    order_d   = order_q;
    sort_en_d = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      elem_d[i] = elem_q[i];
    end

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int i = 0; i < LENGTH; i++) begin
            if (count_q == LEN_WIDTH'(i)) begin
              elem_d[i] = in_data;
            end
          end
          if (count_q == '0) begin
            order_d = in_order;
          end
          count_d = count_next;
        end
        if (launch) begin
          len_d     = count_next;
          sort_en_d = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Clearing on release keeps entries beyond len at zero for the next batch.
        if (sort_done) begin
          state_d = ST_FILL;
          count_d = '0;
          for (int i = 0; i < LENGTH; i++) begin
            elem_d[i] = '0;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FILL;
      count_q   <= '0;
      len_q     <= '0;
      order_q   <= 1'b0;
      sort_en_q <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      order_q   <= order_d;
      sort_en_q <= sort_en_d;
      for (int i = 0; i < LENGTH; i++) begin
        elem_q[i] <= elem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_list_collector.sv
// Self-checking bench for list_collector: queue-based batch model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_list_collector;

  localparam int DW = 32;
  localparam int L  = 8;
  localparam int LW = $clog2(L + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid, in_last, in_order, flush, sort_done;
  logic              in_ready, sort_order, sort_en, busy;
  logic [L*DW-1:0]   data_out;
  logic [LW-1:0]     len;

  int total = 0;
  int bad   = 0;
  int n_sort_en = 0;

  list_collector #(.DATA_WIDTH(DW), .LENGTH(L)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_order(in_order), .in_ready(in_ready),
    .flush(flush), .data_out(data_out), .len(len), .sort_order(sort_order),
    .sort_en(sort_en), .sort_done(sort_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: the batch is just a queue of accepted values.
  int unsigned mq[$];
  bit          m_wait    = 1'b0;
  bit          m_sort_en = 1'b0;
  bit          m_order   = 1'b0;
  int          m_len     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_wait = 1'b0; m_sort_en = 1'b0; m_order = 1'b0; m_len = 0;
    end else begin
      m_sort_en = 1'b0;
      if (!m_wait) begin
        if (in_valid) begin
          if (mq.size() == 0) m_order = in_order;
          mq.push_back(in_data);
        end
        if ((in_valid && (in_last || mq.size() == L)) || (flush && mq.size() > 0)) begin
          m_wait = 1'b1; m_len = mq.size(); m_sort_en = 1'b1;
        end
      end else if (sort_done) begin
        m_wait = 1'b0;
        mq.delete();
      end
    end
  end

  function automatic logic [L*DW-1:0] model_vec();
    logic [L*DW-1:0] v = '0;
    for (int k = 0; k < mq.size(); k++) v[k*DW +: DW] = mq[k];
    return v;
  endfunction

  task automatic chk(input string name, input logic [L*DW-1:0] act, input logic [L*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_wait);
    chk("busy", busy, m_wait);
    chk("sort_en", sort_en, m_sort_en);
    chk("len", len, m_len);
    chk("sort_order", sort_order, m_order);
    chk("data_out", data_out, model_vec());
    if (sort_en === 1'b1) n_sort_en++;
  end

  function automatic int unsigned elem(input int k);
    return data_out[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int unsigned d, input bit last, input bit ord);
    in_valid = 1'b1; in_data = d; in_last = last; in_order = ord;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic done_pulse();
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
  endtask

  // Sorts the DUT's current batch the way the sorter would and compares to a literal list.
  task automatic chain_check(input string name, input int unsigned e0, input int unsigned e1,
                             input int unsigned e2, input int unsigned e3, input int n);
    int unsigned a[L];
    int unsigned e[4];
    int unsigned t;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({name, "_len"}, len, n);
    for (int k = 0; k < L; k++) a[k] = elem(k);
    for (int i = 0; i < n; i++)
      for (int j = 0; j + 1 < n - i; j++)
        if (sort_order ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int k = 0; k < n && k < 4; k++) chk({name, "_elem"}, a[k], e[k]);
  endtask

  int n0;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_order = 1'b0;
    flush = 1'b0; sort_done = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data_out, '0);
    rst = 1'b0;
    tick();

    // 5, 3, 9 with in_last
    beat(5, 0, 0); beat(3, 0, 0); beat(9, 1, 0);
    chk("t1_sort_en", sort_en, 1'b1);
    chk("t1_len", len, 3);
    chk("t1_e0", elem(0), 5);
    chk("t1_e1", elem(1), 3);
    chk("t1_e2", elem(2), 9);
    chk("t1_upper", data_out[L*DW-1:3*DW], '0);
    tick();
    chk("t1_sort_en_off", sort_en, 1'b0);
    chk("t1_in_ready", in_ready, 1'b0);
    chk("t1_busy", busy, 1'b1);
    done_pulse();
    chk("t1_release_ready", in_ready, 1'b1);
    chk("t1_release_clear", data_out, '0);

    // full buffer without in_last, then a rejected 9th beat
    for (int i = 1; i <= L; i++) beat(i, 0, 1);
    chk("t2_sort_en", sort_en, 1'b1);
    chk("t2_len", len, L);
    for (int i = 0; i < 5; i++) beat(99, 0, 0);
    chk("t2_e7_held", elem(7), 8);
    chk("t2_ready", in_ready, 1'b0);
    chk("t2_order", sort_order, 1'b1);
    done_pulse();

    // 2 beats then flush; then flush on empty buffer
    beat(7, 0, 0); beat(4, 0, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_sort_en", sort_en, 1'b1);
    chk("t3_len", len, 2);
    done_pulse();
    n0 = n_sort_en;
    flush = 1'b1; tick(); tick(); tick(); flush = 1'b0; tick();
    chk("t3_empty_flush", n_sort_en, n0);
    chk("t3_len_kept", len, 2);

    // hold stable while waiting, under input noise
    beat(11, 0, 0);
    in_valid = 1'b1; in_data = 22; flush = 1'b1; tick(); in_valid = 1'b0; flush = 1'b0;
    chk("t4_len", len, 2);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
      in_last = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    chk("t4_e0", elem(0), 11);
    chk("t4_e1", elem(1), 22);
    chk("t4_len_held", len, 2);
    done_pulse();
    chk("t4_ready", in_ready, 1'b1);
    chk("t4_clear", data_out, '0);

    // sorter chain
    beat(4, 0, 1); beat(1, 0, 0); beat(3, 0, 0); beat(2, 1, 0);
    chain_check("t5_desc", 4, 3, 2, 1, 4);
    tick(); done_pulse();
    beat(6, 0, 0); beat(5, 1, 1);
    chain_check("t5_asc", 5, 6, 0, 0, 2);
    tick(); done_pulse();

    // reset while waiting
    beat(77, 1, 1);
    tick();
    chk("t6_busy_pre", busy, 1'b1);
    rst = 1'b1; #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_len", len, 0);
    chk("t6_order", sort_order, 1'b0);
    chk("t6_data", data_out, '0);
    tick();
    rst = 1'b0;
    tick();
    beat(42, 1, 0);
    chk("t6_new_len", len, 1);
    chk("t6_new_sort_en", sort_en, 1'b1);
    chk("t6_new_e0", elem(0), 42);
    tick(); done_pulse();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom_range(0, 255);
      in_last   = ($urandom_range(0, 5) == 0);
      in_order  = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 9) == 0);
      sort_done = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; #1;
        chk("rnd_async_rst", busy, 1'b0);
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; sort_done = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
